// File: rtl/countdown_timer_if.sv
// countdown_timer_if: keypad digit, tick and control inputs, and MM:SS display outputs of the countdown timer
interface countdown_timer_if;
  logic       load;
  logic [3:0] digit;
  logic       pgt_1hz;
  logic       start;
  logic       stop;
  logic [3:0] min_tens;
  logic [3:0] min_ones;
  logic [3:0] sec_tens;
  logic [3:0] sec_ones;
  logic       running;
  logic       zero;
  logic       done;
  modport master (
    output load, digit, pgt_1hz, start, stop,
    input  min_tens, min_ones, sec_tens, sec_ones, running, zero, done
  );
  modport slave (
    input  load, digit, pgt_1hz, start, stop,
    output min_tens, min_ones, sec_tens, sec_ones, running, zero, done
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: four-digit BCD MM:SS countdown with keypad shift-in, 1 Hz decrement and pause/cancel
module countdown_timer (
  input logic clk,
  input logic clear,
  countdown_timer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
  state_t state_q, state_d;
  logic [3:0] mt_q, mo_q, st_q, so_q, mt_d, mo_d, st_d, so_d;
  logic load_q, tick_q, start_q, stop_q, running_q, done_q, done_d;
  logic load_rise, tick_rise, start_rise, stop_rise, zero;
  logic [3:0] mt_dec, mo_dec, st_dec, so_dec;
  logic borrow_s, borrow_t, dec_zero;
  assign load_rise  = bus.load & ~load_q;
  assign tick_rise  = bus.pgt_1hz & ~tick_q;
  assign start_rise = bus.start & ~start_q;
  assign stop_rise  = bus.stop & ~stop_q;
  assign zero = ~|{mt_q, mo_q, st_q, so_q};
  // Borrow ripples right-to-left; the 5 reload only applies on a seconds borrow
  assign borrow_s = so_q == 4'd0;
  assign borrow_t = borrow_s && st_q == 4'd0;
  assign so_dec = borrow_s ? 4'd9 : so_q - 4'd1;
  assign st_dec = borrow_s ? (st_q == 4'd0 ? 4'd5 : st_q - 4'd1) : st_q;
  assign mo_dec = borrow_t ? (mo_q == 4'd0 ? 4'd9 : mo_q - 4'd1) : mo_q;
  assign mt_dec = (borrow_t && mo_q == 4'd0) ? mt_q - 4'd1 : mt_q;
  assign dec_zero = ~|{mt_dec, mo_dec, st_dec, so_dec};
  always_comb begin
    state_d = state_q;
    {mt_d, mo_d, st_d, so_d} = {mt_q, mo_q, st_q, so_q};
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (stop_rise) {mt_d, mo_d, st_d, so_d} = '0;
        else begin
          if (load_rise && bus.digit <= 4'd9) {mt_d, mo_d, st_d, so_d} = {mo_q, st_q, so_q, bus.digit};
          if (start_rise && !zero) state_d = RUN;
        end
      end
      RUN: begin
        if (tick_rise) {mt_d, mo_d, st_d, so_d} = {mt_dec, mo_dec, st_dec, so_dec};
        if (tick_rise && dec_zero) begin
          done_d = 1'b1;
          state_d = IDLE;
        end else if (stop_rise) state_d = PAUSE;
      end
      PAUSE: begin
        if (stop_rise) begin
          {mt_d, mo_d, st_d, so_d} = '0;
          state_d = IDLE;
        end else if (start_rise) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      state_q <= IDLE;
      {mt_q, mo_q, st_q, so_q} <= '0;
      {load_q, tick_q, start_q, stop_q} <= '0;
      running_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      {mt_q, mo_q, st_q, so_q} <= {mt_d, mo_d, st_d, so_d};
      {load_q, tick_q, start_q, stop_q} <= {bus.load, bus.pgt_1hz, bus.start, bus.stop};
      running_q <= state_d == RUN;
      done_q <= done_d;
    end
  end
  assign bus.min_tens = mt_q;
  assign bus.min_ones = mo_q;
  assign bus.sec_tens = st_q;
  assign bus.sec_ones = so_q;
  assign bus.running = running_q;
  assign bus.zero = zero;
  assign bus.done = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: table-driven vectors plus directed multi-cycle sequences for countdown_timer
module tb_countdown_timer;
  logic clk = 1'b0;
  logic clear = 1'b1;
  countdown_timer_if bus();
  countdown_timer dut (.clk(clk), .clear(clear), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {
    logic l; logic [3:0] d; logic t; logic s; logic p;
    logic [15:0] dig; logic r; logic z; logic dn;
  } vec_t;
  vec_t vec [27];
  int errors = 0;
  int checks = 0;
  function automatic logic [18:0] obs();
    return {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones, bus.running, bus.zero, bus.done};
  endfunction
  task automatic check(input string name, input logic [18:0] got, input logic [18:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got digits=%h run=%b zero=%b done=%b, expected digits=%h run=%b zero=%b done=%b",
               name, got[18:3], got[2], got[1], got[0], exp[18:3], exp[2], exp[1], exp[0]);
    end
  endtask
  task automatic cyc(input logic l, input logic [3:0] d, input logic t, input logic s, input logic p);
    bus.load = l; bus.digit = d; bus.pgt_1hz = t; bus.start = s; bus.stop = p;
    @(posedge clk); #1;
  endtask
  task automatic enter(input logic [15:0] v);
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
    for (int i = 3; i >= 0; i--) begin
      cyc(1, v[i*4 +: 4], 0, 0, 0); cyc(0, 0, 0, 0, 0);
    end
  endtask
  task automatic pulse_start(); cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0); endtask
  task automatic pulse_stop();  cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0); endtask
  task automatic tick();        cyc(0, 0, 1, 0, 0); cyc(0, 0, 0, 0, 0); endtask
  initial begin
    vec[0]  = '{1, 4'd1, 0, 0, 0, 16'h0001, 0, 0, 0};
    vec[1]  = '{1, 4'd1, 0, 0, 0, 16'h0001, 0, 0, 0};
    vec[2]  = '{0, 4'd0, 0, 0, 0, 16'h0001, 0, 0, 0};
    vec[3]  = '{1, 4'd2, 0, 0, 0, 16'h0012, 0, 0, 0};
    vec[4]  = '{0, 4'd0, 0, 0, 0, 16'h0012, 0, 0, 0};
    vec[5]  = '{1, 4'd3, 0, 0, 0, 16'h0123, 0, 0, 0};
    vec[6]  = '{0, 4'd0, 0, 0, 0, 16'h0123, 0, 0, 0};
    vec[7]  = '{1, 4'd4, 0, 0, 0, 16'h1234, 0, 0, 0};
    vec[8]  = '{0, 4'd0, 0, 0, 0, 16'h1234, 0, 0, 0};
    vec[9]  = '{1, 4'd7, 0, 0, 0, 16'h2347, 0, 0, 0};
    vec[10] = '{0, 4'd0, 0, 0, 0, 16'h2347, 0, 0, 0};
    vec[11] = '{1, 4'd12, 0, 0, 0, 16'h2347, 0, 0, 0};
    vec[12] = '{0, 4'd0, 0, 0, 0, 16'h2347, 0, 0, 0};
    vec[13] = '{0, 4'd0, 0, 1, 0, 16'h2347, 1, 0, 0};
    vec[14] = '{0, 4'd0, 1, 0, 0, 16'h2346, 1, 0, 0};
    vec[15] = '{0, 4'd0, 1, 0, 0, 16'h2346, 1, 0, 0};
    vec[16] = '{1, 4'd5, 0, 0, 0, 16'h2346, 1, 0, 0};
    vec[17] = '{1, 4'd5, 1, 0, 0, 16'h2345, 1, 0, 0};
    vec[18] = '{0, 4'd0, 1, 0, 1, 16'h2345, 0, 0, 0};
    vec[19] = '{0, 4'd0, 0, 0, 0, 16'h2345, 0, 0, 0};
    vec[20] = '{0, 4'd0, 1, 0, 0, 16'h2345, 0, 0, 0};
    vec[21] = '{0, 4'd0, 0, 1, 0, 16'h2345, 1, 0, 0};
    vec[22] = '{0, 4'd0, 0, 0, 1, 16'h2345, 0, 0, 0};
    vec[23] = '{0, 4'd0, 0, 0, 0, 16'h2345, 0, 0, 0};
    vec[24] = '{0, 4'd0, 0, 0, 1, 16'h0000, 0, 1, 0};
    vec[25] = '{0, 4'd0, 0, 1, 0, 16'h0000, 0, 1, 0};
    vec[26] = '{0, 4'd0, 0, 0, 0, 16'h0000, 0, 1, 0};
    {bus.load, bus.digit, bus.pgt_1hz, bus.start, bus.stop} = '0;
    repeat (2) @(posedge clk);
    #1 check("reset", obs(), {16'h0000, 3'b010});
    clear = 1'b0;
    cyc(0, 0, 0, 0, 0);
    for (int i = 0; i < 27; i++) begin
      cyc(vec[i].l, vec[i].d, vec[i].t, vec[i].s, vec[i].p);
      check($sformatf("vec%0d", i), obs(), {vec[i].dig, vec[i].r, vec[i].z, vec[i].dn});
    end
    enter(16'h0100);
    pulse_start();
    tick();
    check("first_tick_0059", obs(), {16'h0059, 3'b100});
    for (int i = 0; i < 58; i++) tick();
    check("at_0001", obs(), {16'h0001, 3'b100});
    cyc(0, 0, 1, 0, 0);
    check("done_pulse", obs(), {16'h0000, 3'b011});
    cyc(0, 0, 0, 0, 0);
    check("done_drop", obs(), {16'h0000, 3'b010});
    enter(16'h1000);
    pulse_start();
    tick();
    check("borrow_0959", obs(), {16'h0959, 3'b100});
    pulse_stop(); pulse_stop();
    enter(16'h0099);
    pulse_start();
    tick();
    check("tens_gt5_0098", obs(), {16'h0098, 3'b100});
    pulse_stop(); pulse_stop();
    enter(16'h0030);
    pulse_start();
    pulse_stop();
    check("pause", obs(), {16'h0030, 3'b000});
    for (int i = 0; i < 5; i++) tick();
    check("pause_ticks", obs(), {16'h0030, 3'b000});
    pulse_start();
    check("resume", obs(), {16'h0030, 3'b100});
    tick();
    check("resume_tick", obs(), {16'h0029, 3'b100});
    pulse_stop();
    cyc(0, 0, 0, 0, 1);
    check("cancel", obs(), {16'h0000, 3'b010});
    cyc(0, 0, 0, 0, 0);
    check("cancel_nodone", obs(), {16'h0000, 3'b010});
    enter(16'h0001);
    pulse_start();
    cyc(0, 0, 1, 0, 1);
    check("tick_stop_done", obs(), {16'h0000, 3'b011});
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0);
    check("start_at_zero", obs(), {16'h0000, 3'b010});
    cyc(0, 0, 0, 0, 0);
    enter(16'h0500);
    pulse_start();
    check("run_0500", obs(), {16'h0500, 3'b100});
    @(posedge clk); #3 clear = 1'b1;
    #1 check("async_clear", obs(), {16'h0000, 3'b010});
    #3 clear = 1'b0;
    cyc(0, 0, 1, 0, 0);
    check("after_clear", obs(), {16'h0000, 3'b010});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end
endmodule
